// File: rtl/fir_decim_cfg.sv
// Configuration sequencer for the 4-channel decimating FIR: streams coefficients, writes the rate word,
// optionally flushes stale history (macro FIR_DECIM_CFG_FLUSH_EN) and gates the output strobe meanwhile.
module fir_decim_cfg #(
  parameter int TIMEOUT = 1024,
  parameter int FLUSH   = 4
) (
  input  logic        c,
  input  logic        r,
  input  logic        req,
  input  logic [1:0]  req_l2n,
  input  logic [17:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] cd,
  output logic        cw,
  input  logic        f_ov,
  output logic        ov,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RATE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t state, state_n;

  logic [1:0]    l2n;
  logic [7:0]    idx;
  logic [7:0]    last_idx;
  logic [TW-1:0] tmo;
  logic          mute;
  logic          hs;
  logic          tmo_hit;

`ifdef FIR_DECIM_CFG_FLUSH_EN
  localparam int FW = $clog2(FLUSH + 1);
  logic [FW-1:0] fcnt;
  logic          flush_hit;
  assign flush_hit = f_ov && (fcnt == FW'(FLUSH - 1));
`endif

  assign s_ready = (state == ST_LOAD);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign ov      = f_ov & ~mute;
  assign hs      = s_ready & s_valid;
  assign tmo_hit = (state == ST_LOAD) && !s_valid && (tmo == TW'(TIMEOUT - 1));

  always_comb begin
    last_idx = 8'd31;
    case (l2n)
      2'd0: last_idx = 8'd31;
      2'd1: last_idx = 8'd63;
      2'd2: last_idx = 8'd127;
      2'd3: last_idx = 8'd255;
      default: last_idx = 8'd31;
    endcase
  end

  always_ff @(posedge c or posedge r) begin
    if (r) state <= ST_IDLE;
    else   state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (req) state_n = ST_LOAD;
      ST_LOAD: begin
        if (hs && (idx == last_idx)) state_n = ST_RATE;
        else if (tmo_hit)            state_n = ST_IDLE;
      end
`ifdef FIR_DECIM_CFG_FLUSH_EN
      ST_RATE:  state_n = ST_FLUSH;
      ST_FLUSH: if (flush_hit) state_n = ST_DONE;
`else
      ST_RATE:  state_n = ST_DONE;
`endif
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: cd/cw are registered so each write lands one cycle after the state that produced it.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      l2n  <= 2'd0;
      idx  <= 8'd0;
      tmo  <= '0;
      err  <= 1'b0;
      mute <= 1'b1;
      cd   <= 32'd0;
      cw   <= 1'b0;
`ifdef FIR_DECIM_CFG_FLUSH_EN
      fcnt <= '0;
`endif
    end else begin
      cw <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            l2n  <= req_l2n;
            idx  <= 8'd0;
            tmo  <= '0;
            err  <= 1'b0;
            mute <= 1'b1;
`ifdef FIR_DECIM_CFG_FLUSH_EN
            fcnt <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (hs) begin
            cd  <= {idx, 6'b0, s_data};
            cw  <= 1'b1;
            idx <= idx + 8'd1;
            tmo <= '0;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_RATE: begin
          cd <= 32'h0004_0000 | {30'd0, l2n};
          cw <= 1'b1;
        end
`ifdef FIR_DECIM_CFG_FLUSH_EN
        ST_FLUSH: begin
          if (f_ov) fcnt <= fcnt + 1'b1;
        end
`endif
        default: ;
      endcase
      // Unmute on entry to DONE so the filter output is live from the completion cycle onward.
      if (state_n == ST_DONE) mute <= 1'b0;
    end
  end

endmodule
